mem_access_unit: RTL and testbench

Memory-stage load/store sequencer for the xgriscv pipeline. It accepts one load or store per request from the MEM stage and computes the byte-enable pattern and lane-replicated store data. It runs a req/ack transaction on the data-memory bus and sign- or zero-extends the returned load data. It stalls the pipeline for the whole transaction and sits between the MEM pipeline register and the data memory.

---
 rtl/mem_access_unit_pkg.sv | 35 +++
 rtl/mem_access_unit_ampattern.sv | 20 ++
 rtl/mem_access_unit_load_extract.sv | 27 ++
 rtl/mem_access_unit.sv | 99 +++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, LSU state encodings and store-lane helpers for the
// memory-stage access unit.
package mem_access_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SWHB_WORD = 2'b01;
  localparam logic [1:0] SWHB_HALF = 2'b10;
  localparam logic [1:0] SWHB_BYTE = 2'b11;

  localparam logic [1:0] LSU_IDLE = 2'b00;
  localparam logic [1:0] LSU_BUSY = 2'b01;
  localparam logic [1:0] LSU_DONE = 2'b10;

  typedef struct packed {
    logic [1:0] size;
    logic       lunsigned;
    logic [1:0] off;
  } lsu_req_t;

  // Size code 00 is legal and behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] swhb);
    return (swhb == 2'b00) ? SWHB_WORD : swhb;
  endfunction

  function automatic logic [XLEN-1:0] replicate_store(input logic [1:0] size,
                                                      input logic [XLEN-1:0] wdata);
    case (norm_size(size))
      SWHB_BYTE: return {4{wdata[7:0]}};
      SWHB_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_ampattern.sv
// Byte-enable pattern generator: maps access size and low address bits to
// the four byte-lane enables of the data bus.
module ampattern
  import mem_access_unit_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] swhb,
  output logic [3:0] amp
);

  always_comb begin
    amp = 4'b1111;
    case (norm_size(swhb))
      SWHB_HALF: amp = addr[1] ? 4'b1100 : 4'b0011;
      SWHB_BYTE: amp = 4'b0001 << addr;
      default:   amp = 4'b1111;
    endcase
  end

endmodule

// File: rtl/mem_access_unit_load_extract.sv
// Pulls the addressed byte/half out of a returned memory word and sign- or
// zero-extends it; word loads pass through untouched.
module load_extract
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [1:0]      swhb,
  input  logic            lunsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr, 3'b000} +: 8];
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (norm_size(swhb))
      SWHB_BYTE: data = {{(XLEN-8){~lunsigned & byte_v[7]}}, byte_v};
      SWHB_HALF: data = {{(XLEN-16){~lunsigned & half_v[15]}}, half_v};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: runs one req/ack bus transaction per
// MEM-stage access and stalls the pipeline until it completes.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      swhb,
  input  logic            lunsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  logic [1:0]      state;
  lsu_req_t        lat;
  logic [1:0]      size;
  logic [3:0]      be_next;
  logic [XLEN-1:0] load_data;
  logic            in_idle;
  logic            accept;

  assign size     = norm_size(swhb);
  assign in_idle  = (state == LSU_IDLE);
  assign misalign = in_idle && req &&
                    ((size == SWHB_HALF && addr[0]) ||
                     (size == SWHB_WORD && addr[1:0] != 2'b00));
  assign accept   = in_idle && req && !misalign;
  assign stall    = accept || (state == LSU_BUSY);
  assign done     = (state == LSU_DONE);

  ampattern u_ampattern (
    .addr (addr[1:0]),
    .swhb (swhb),
    .amp  (be_next)
  );

  // Extraction uses the latched request, since the MEM stage inputs are
  // only guaranteed during the accept cycle.
  load_extract u_load_extract (
    .rdata     (bus_rdata),
    .addr      (lat.off),
    .swhb      (lat.size),
    .lunsigned (lat.lunsigned),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LSU_IDLE;
      lat       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            lat.size      <= size;
            lat.lunsigned <= lunsigned;
            lat.off       <= addr[1:0];
            bus_req       <= 1'b1;
            bus_we        <= we;
            bus_addr      <= {addr[XLEN-1:2], 2'b00};
            bus_be        <= be_next;
            bus_wdata     <= replicate_store(size, wdata);
            state         <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (bus_ack) begin
            if (!bus_we) rdata <= load_data;
            bus_req <= 1'b0;
            state   <= LSU_DONE;
          end
        end
        // req is still the completed instruction here, so it is not sampled.
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scoreboarded load/store
// transactions plus misalign, ack-in-idle and mid-transaction reset cases.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  swhb;
  logic        lunsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct {
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load = 32'h0;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .swhb      (swhb),
    .lunsigned (lunsigned),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Starts at a negedge, runs one access to completion, returns at the
  // negedge that follows the DONE cycle (req is left asserted).
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rword, input int delay,
                               input logic [31:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic [31:0] e_load);
    exp_t e;
    int   stall_cnt;
    int   busy;
    bit   got;
    stall_cnt = 0;
    busy      = 0;
    got       = 0;
    e.rdata   = st ? last_load : e_load;
    e.cycles  = delay + 3;
    if (!st) last_load = e_load;
    exp_q.push_back(e);
    req = 1'b1; we = st; swhb = sz; lunsigned = uns; addr = a; wdata = wd;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      #1;
      if (cyc == 0) begin
        checkOutput("accept_misalign", 32'(misalign), 32'h0);
        checkOutput("accept_bus_req", 32'(bus_req), 32'h0);
      end
      if (done) begin
        got = 1;
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_empty", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_stall", 32'(stall), 32'h0);
          checkOutput("done_bus_req", 32'(bus_req), 32'h0);
          checkOutput("latency", 32'(cyc + 1), 32'(e.cycles));
          checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.cycles - 1));
          checkOutput("rdata", rdata, e.rdata);
        end
      end else begin
        if (stall) stall_cnt++;
        if (bus_req) begin
          if (busy == 0) begin
            checkOutput("bus_addr", bus_addr, e_addr);
            checkOutput("bus_be", 32'(bus_be), 32'(e_be));
            checkOutput("bus_we", 32'(bus_we), 32'(st));
            if (st) checkOutput("bus_wdata", bus_wdata, e_wdata);
          end
          if (busy == delay) begin
            bus_ack   = 1'b1;
            bus_rdata = rword;
          end
          busy++;
        end
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    if (!got) checkOutput("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic idleCycle();
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; swhb = 2'b00; lunsigned = 1'b0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_bus_req", 32'(bus_req), 32'h0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_be", 32'(bus_be), 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] word store, ack on second BUSY cycle");
    applyStimulus(1'b1, SWHB_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 1,
                  32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
    idleCycle();

    $display("[TB] LB then LBU back-to-back, immediate ack");
    applyStimulus(1'b0, SWHB_BYTE, 1'b0, 32'h203, 32'h0, 32'h80112233, 0,
                  32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
    applyStimulus(1'b0, SWHB_BYTE, 1'b1, 32'h203, 32'h0, 32'h80112233, 0,
                  32'h200, 4'b1000, 32'h0, 32'h00000080);
    idleCycle();

    $display("[TB] half store");
    applyStimulus(1'b1, SWHB_HALF, 1'b0, 32'h302, 32'h0000ABCD, 32'h0, 2,
                  32'h300, 4'b1100, 32'hABCDABCD, 32'h0);
    idleCycle();

    $display("[TB] LH lane 0 then LHU lane 1 back-to-back");
    applyStimulus(1'b0, SWHB_HALF, 1'b0, 32'h500, 32'h0, 32'h12348765, 0,
                  32'h500, 4'b0011, 32'h0, 32'hFFFF8765);
    applyStimulus(1'b0, SWHB_HALF, 1'b1, 32'h502, 32'h0, 32'h80010000, 0,
                  32'h500, 4'b1100, 32'h0, 32'h00008001);
    idleCycle();

    $display("[TB] byte store, size-00 word load, positive LB");
    applyStimulus(1'b1, SWHB_BYTE, 1'b0, 32'h601, 32'h12345678, 32'h0, 1,
                  32'h600, 4'b0010, 32'h78787878, 32'h0);
    idleCycle();
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h700, 32'h0, 32'hA5A55A5A, 0,
                  32'h700, 4'b1111, 32'h0, 32'hA5A55A5A);
    idleCycle();
    applyStimulus(1'b0, SWHB_BYTE, 1'b0, 32'h7F1, 32'h0, 32'h00007F00, 0,
                  32'h7F0, 4'b0010, 32'h0, 32'h0000007F);
    idleCycle();

    $display("[TB] bus_ack while idle");
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checkOutput("idle_ack_stall", 32'(stall), 32'h0);
    checkOutput("idle_ack_done", 32'(done), 32'h0);
    checkOutput("idle_ack_bus_req", 32'(bus_req), 32'h0);
    checkOutput("idle_ack_rdata", rdata, last_load);
    @(negedge clk);

    $display("[TB] misaligned accesses");
    req = 1'b1; we = 1'b0; swhb = SWHB_WORD; lunsigned = 1'b0; addr = 32'h401;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("mis_lw_flag", 32'(misalign), 32'h1);
      checkOutput("mis_lw_stall", 32'(stall), 32'h0);
      checkOutput("mis_lw_bus_req", 32'(bus_req), 32'h0);
      @(negedge clk);
    end
    swhb = SWHB_HALF; addr = 32'h303;
    #1;
    checkOutput("mis_lh_flag", 32'(misalign), 32'h1);
    swhb = SWHB_BYTE;
    #1;
    checkOutput("odd_lb_flag", 32'(misalign), 32'h0);
    checkOutput("odd_lb_stall", 32'(stall), 32'h1);
    req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mis_after_bus_req", 32'(bus_req), 32'h0);
    @(negedge clk);

    $display("[TB] reset during BUSY");
    req = 1'b1; we = 1'b0; swhb = SWHB_WORD; addr = 32'h800;
    @(negedge clk);
    #1;
    checkOutput("busy_bus_req", 32'(bus_req), 32'h1);
    #1;
    reset = 1'b1; req = 1'b0;
    #1;
    checkOutput("rst_busy_bus_req", 32'(bus_req), 32'h0);
    checkOutput("rst_busy_stall", 32'(stall), 32'h0);
    checkOutput("rst_busy_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    applyStimulus(1'b0, SWHB_WORD, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 0,
                  32'h0, 4'b1111, 32'h0, 32'hCAFEF00D);
    idleCycle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
